// File: rtl/pic_pkg.sv
// Shared definitions for the PIC interrupt-acknowledge initiator and the PIC responder.
package pic_pkg;

  localparam logic [7:0] OCW3_POLL = 8'h0C;
  localparam logic [3:0] SEL_BYTE0 = 4'b0001;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_GAP   = 3'd2,
    ST_RD    = 3'd3,
    ST_VALID = 3'd4
  } pic_state_e;

endpackage

// File: rtl/pic_int_ack_master_if.sv
// Wishbone signal bundle between the interrupt-acknowledge initiator and the PIC responder.
interface pic_int_ack_master_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/pic_int_ack_master_wb_timeout_cnt.sv
// Bus watchdog: counts strobe cycles without acknowledge; expired marks the cycle
// whose increment would reach TIMEOUT, so the strobe stays high exactly TIMEOUT cycles.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (count_en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = count_en_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/pic_int_ack_master.sv
// CPU-side interrupt acknowledge: polls the PIC over Wishbone (OCW3 write, code read)
// and hands VEC_BASE+code to the CPU with a req/ack handshake.
module pic_int_ack_master
  import pic_pkg::*;
#(
  parameter logic [31:0] PIC_BASE = 32'h1000_0000,
  parameter logic [7:0]  VEC_BASE = 8'h20,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  pic_int_ack_master_if.master wb,
  input  logic                 int_i,
  input  logic                 enable_i,
  output logic                 irq_req_o,
  output logic [7:0]           irq_vec_o,
  input  logic                 irq_ack_i,
  output logic                 err_o
);
  pic_state_e  state_q, state_d;
  logic        pending_q, pending_d;
  logic [7:0]  vec_q, vec_d;
  logic        err_q, err_d;
  logic        clr_pend;
  logic        bus_act;
  logic        expired;

  // Bus outputs decode straight from the state flop so an async reset drops them at once.
  assign bus_act   = (state_q == ST_WR) || (state_q == ST_RD);
  assign wb.cyc_o  = bus_act;
  assign wb.stb_o  = bus_act;
  assign wb.we_o   = (state_q == ST_WR);
  assign wb.sel_o  = bus_act ? SEL_BYTE0 : '0;
  assign wb.adr_o  = bus_act ? PIC_BASE : '0;
  assign wb.dat_o  = (state_q == ST_WR) ? {24'h0, OCW3_POLL} : '0;

  assign irq_req_o = (state_q == ST_VALID);
  assign irq_vec_o = vec_q;
  assign err_o     = err_q;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (!bus_act),
    .count_en_i (bus_act && !wb.ack_i),
    .expired_o  (expired)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = 1'b0;
    clr_pend = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q && enable_i) begin
          state_d  = ST_WR;
          clr_pend = 1'b1;
        end
      end
      ST_WR: begin
        if (wb.ack_i) begin
          state_d = ST_GAP;
        end else if (expired) begin
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          clr_pend = 1'b1;
        end
      end
      ST_GAP: state_d = ST_RD;
      ST_RD: begin
        if (wb.ack_i) begin
          vec_d   = VEC_BASE + {5'b0, wb.dat_i[CODE_W-1:0]};
          state_d = ST_VALID;
        end else if (expired) begin
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          clr_pend = 1'b1;
        end
      end
      ST_VALID: begin
        if (irq_ack_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new pulse on the clearing edge survives so it is not lost.
    pending_d = int_i || (pending_q && !clr_pend);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      vec_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      vec_q     <= vec_d;
      err_q     <= err_d;
    end
  end
endmodule
